// File: rtl/skullfet_pkg.sv
// skullfet_pkg: shared FSM state type, register word offsets and CTRL bit positions
// for skullfet_freq_meter.
package skullfet_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_GATE   = 2'd1;
    localparam logic [1:0] REG_RESULT = 2'd2;
    localparam logic [1:0] REG_LEVEL  = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_BUSY  = 1;
    localparam int CTRL_DONE  = 2;
    localparam int CTRL_OVF   = 3;

endpackage

// File: rtl/skullfet_sync.sv
// skullfet_sync: input synchronizer and rising-edge detector; defining
// SKULLFET_FMETER_GLITCH_FILTER_EN inserts a 3-sample majority filter before edge detection.
module skullfet_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_lvl;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
    end

`ifdef SKULLFET_FMETER_GLITCH_FILTER_EN
    logic [1:0] r_hist;
    logic       r_maj;
    logic       w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Majority of the current and two previous samples; a lone 1-cycle pulse never wins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hist <= '0;
            r_maj  <= 1'b0;
        end else begin
            r_hist <= {r_hist[0], w_s};
            r_maj  <= (w_s & r_hist[0]) | (w_s & r_hist[1]) | (r_hist[0] & r_hist[1]);
        end
    end

    assign w_lvl = r_maj;
`else
    assign w_lvl = r_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_prev <= 1'b0;
        else       r_prev <= w_lvl;
    end

    assign o_level = w_lvl;
    assign o_rise  = w_lvl & ~r_prev;

endmodule

// File: rtl/skullfet_freq_meter.sv
// skullfet_freq_meter: Wishbone-mapped gated rising-edge counter for the skullfet_inverter pad.
// Define SKULLFET_FMETER_GLITCH_FILTER_EN to enable the majority glitch filter in skullfet_sync.
module skullfet_freq_meter
    import skullfet_pkg::*;
#(
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        sig_in,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o
);

    state_t             r_state;
    logic [31:0]        r_gate;
    logic [31:0]        r_gate_cnt;
    logic [CNT_W-1:0]   r_edges;
    logic [CNT_W-1:0]   r_result;
    logic               r_ovf;
    logic               r_irq;
    logic               r_ack;
    logic               r_hold;
    logic [31:0]        r_dat;

    logic               w_level;
    logic               w_rise;
    logic               w_req;
    logic               w_wr;
    logic [1:0]         w_reg;
    logic               w_ctrl_wr;
    logic               w_start;
    logic               w_clr_done;
    logic               w_clr_ovf;
    logic               w_max;
    logic [CNT_W-1:0]   w_next;
    logic [31:0]        w_mask;
    logic [31:0]        w_rdata;
    logic               w_unused;

    skullfet_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_sig   (sig_in),
        .o_level (w_level),
        .o_rise  (w_rise)
    );

    // r_hold blocks a second request until the master drops stb.
    assign w_req      = wbs_stb_i & wbs_cyc_i & ~r_hold;
    assign w_wr       = w_req & wbs_we_i;
    assign w_reg      = wbs_adr_i[3:2];
    assign w_ctrl_wr  = w_wr & (w_reg == REG_CTRL) & wbs_sel_i[0];
    assign w_start    = w_ctrl_wr & wbs_dat_i[CTRL_START] & (r_state != ST_COUNT);
    assign w_clr_done = w_ctrl_wr & wbs_dat_i[CTRL_DONE];
    assign w_clr_ovf  = w_ctrl_wr & wbs_dat_i[CTRL_OVF];
    assign w_max      = &r_edges;
    assign w_next     = r_edges + CNT_W'(w_rise & ~w_max);
    assign w_mask     = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign w_unused   = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};

    assign w_rdata = (w_reg == REG_CTRL)   ? {28'd0, r_ovf, r_state == ST_DONE, r_state == ST_COUNT, 1'b0} :
                     (w_reg == REG_GATE)   ? r_gate :
                     (w_reg == REG_RESULT) ? 32'(r_result) :
                                             {31'd0, w_level};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack  <= 1'b0;
            r_hold <= 1'b0;
            r_dat  <= '0;
        end else begin
            r_ack  <= w_req;
            r_hold <= w_req | (r_hold & wbs_stb_i);
            r_dat  <= (w_req & ~wbs_we_i) ? w_rdata : '0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)                          r_gate <= '0;
        else if (w_wr && w_reg == REG_GATE)    r_gate <= (wbs_dat_i & w_mask) | (r_gate & ~w_mask);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_IDLE;
            r_gate_cnt <= '0;
            r_edges    <= '0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            if (w_clr_ovf) r_ovf <= 1'b0;
            if (w_start) begin
                r_edges    <= '0;
                r_gate_cnt <= r_gate;
                r_state    <= (r_gate == '0) ? ST_DONE : ST_COUNT;
                if (r_gate == '0) begin
                    r_result <= '0;
                    r_irq    <= 1'b1;
                end
            end else if (r_state == ST_COUNT) begin
                // The edge seen on the final gate cycle still lands in RESULT via w_next.
                r_edges    <= w_next;
                r_gate_cnt <= r_gate_cnt - 32'd1;
                if (w_rise && w_max) r_ovf <= 1'b1;
                if (r_gate_cnt == 32'd1) begin
                    r_state  <= ST_DONE;
                    r_result <= w_next;
                    r_irq    <= 1'b1;
                end
            end else if (r_state == ST_DONE && w_clr_done) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign irq_o     = r_irq;

endmodule

// File: tb/tb_skullfet_freq_meter.sv
// tb_skullfet_freq_meter: table-driven and randomized checks of skullfet_freq_meter,
// run on a 24-bit and an 8-bit counter instance sharing the same stimulus.
module tb_skullfet_freq_meter;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sig = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic        ack, ack8, irq, irq8;
    logic [31:0] rdat, rdat8;

    int pass_n = 0;
    int total_n = 0;
    int edge_n = 0;
    int irq_cnt = 0;
    int irq8_cnt = 0;
    int irq_edge = -1;
    int mode = 0;
    bit hist [0:99999];

    skullfet_freq_meter #(.CNT_W(24), .SYNC_STAGES(S)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .sig_in(sig),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat), .irq_o(irq)
    );

    skullfet_freq_meter #(.CNT_W(8), .SYNC_STAGES(S)) u_dut8 (
        .wb_clk_i(clk), .wb_rst_i(rst), .sig_in(sig),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack8), .wbs_dat_o(rdat8), .irq_o(irq8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk) begin
        if (irq) begin
            irq_cnt  <= irq_cnt + 1;
            irq_edge <= edge_n;
        end
        if (irq8) irq8_cnt <= irq8_cnt + 1;
    end

    // mode: 0 low, -3 high, -1 random, -2 one-cycle pulse every 5 cycles, >0 square half-period
    initial begin : drive_sig
        int ph;
        bit v;
        ph = 0;
        forever begin
            @(negedge clk);
            ph++;
            v = (mode > 0)   ? bit'((ph / mode) % 2) :
                (mode == -1) ? bit'($urandom_range(0, 1)) :
                (mode == -2) ? (ph % 5 == 0) :
                               (mode == -3);
            sig = v;
            hist[edge_n + 1] = v;
        end
    end

    // Synchronized level seen at clock edge k, as it appears to the edge detector.
    function automatic bit lvl(input int k);
`ifdef SKULLFET_FMETER_GLITCH_FILTER_EN
        int c;
        c = int'(hist[k-S-1]) + int'(hist[k-S-2]) + int'(hist[k-S-3]);
        return c >= 2;
`else
        return hist[k-S];
`endif
    endfunction

    function automatic int raw_edges(input int e0, input int n);
        int c;
        c = 0;
        for (int k = e0 + 1; k <= e0 + n; k++) if (lvl(k) && !lvl(k-1)) c++;
        return c;
    endfunction

    function automatic int sat(input int raw, input int w);
        int m;
        m = (w >= 31) ? 32'h7fffffff : (1 << w) - 1;
        return (raw > m) ? m : raw;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int e0);
        int n;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
        e0 = edge_n + 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        if (!ack) chk("write_ack_timeout", 32'd0, 32'd1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output logic [31:0] d8);
        int n;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        if (!ack) chk("read_ack_timeout", 32'd0, 32'd1);
        d = rdat; d8 = rdat8;
        stb = 1'b0; cyc = 1'b0;
        @(negedge clk);
        chk("dat_idle_zero", rdat | rdat8, 32'd0);
    endtask

    task automatic run_row(input int gate, input int m, input int lo, input int hi, input int ovf8, input string tag);
        int e, e0, b, b8, raw;
        logic [31:0] r, r8;
        mode = m;
        repeat (8) @(negedge clk);
        wb_write(32'h4, gate, 4'hF, e);
        b = irq_cnt; b8 = irq8_cnt;
        wb_write(32'h0, 32'h1, 4'h1, e0);
        repeat (gate + 6) @(negedge clk);
        raw = raw_edges(e0, gate);
        chk({tag, "_irq_pulses"}, irq_cnt - b, 32'd1);
        chk({tag, "_irq8_pulses"}, irq8_cnt - b8, 32'd1);
        chk({tag, "_irq_edge"}, irq_edge, e0 + gate);
        wb_read(32'h8, r, r8);
        chk({tag, "_result"}, r, sat(raw, 24));
        chk({tag, "_result_range"}, 32'((r >= lo) && (r <= hi)), 32'd1);
        chk({tag, "_result8"}, r8, sat(raw, 8));
        wb_read(32'h0, r, r8);
        chk({tag, "_ctrl"}, r, 32'd4);
        chk({tag, "_ctrl8"}, r8, (raw > 255) ? 32'hC : 32'h4);
        if (ovf8 >= 0) chk({tag, "_ovf8"}, r8[3], ovf8);
        wb_write(32'h0, 32'hC, 4'h1, e);
        wb_read(32'h0, r, r8);
        chk({tag, "_ctrl_cleared"}, r | r8, 32'd0);
    endtask

    typedef struct {
        int gate;
        int m;
        int lo;
        int hi;
        int ovf8;
    } row_t;

    initial begin : main
        row_t rows [6];
        logic [31:0] r, r8;
        int e, e0, e1, b, raw, ra, n;

        rows[0] = '{100, 5, 9, 11, 0};
        rows[1] = '{1000, 1, 499, 501, 1};
        rows[2] = '{0, 3, 0, 0, 0};
        rows[3] = '{1, 1, 0, 1, 0};
        rows[4] = '{37, 2, 8, 10, 0};
        rows[5] = '{600, -1, 0, 300, -1};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {29'd0, ack, irq, |rdat}, 32'd0);
        chk("reset_outputs8", {29'd0, ack8, irq8, |rdat8}, 32'd0);
        rst = 1'b0;
        wb_read(32'h0, r, r8);
        chk("reset_ctrl", r | r8, 32'd0);
        wb_read(32'h4, r, r8);
        chk("reset_gate", r | r8, 32'd0);
        wb_read(32'h8, r, r8);
        chk("reset_result", r | r8, 32'd0);

        for (int i = 0; i < 6; i++)
            run_row(rows[i].gate, rows[i].m, rows[i].lo, rows[i].hi, rows[i].ovf8, $sformatf("row%0d", i));
        for (int i = 0; i < 3; i++) begin
            n = $urandom_range(1, 400);
            run_row(n, -1, 0, n, -1, $sformatf("rand%0d", i));
        end

        // A second start mid-count must not reload the gate or shift completion.
        mode = 5;
        wb_write(32'h4, 32'd200, 4'hF, e);
        b = irq_cnt;
        wb_write(32'h0, 32'h1, 4'h1, e0);
        repeat (50) @(negedge clk);
        wb_read(32'h0, r, r8);
        chk("midcount_busy", r, 32'd2);
        wb_write(32'h4, 32'd7, 4'hF, e);
        wb_write(32'h0, 32'h1, 4'h1, e1);
        repeat (200) @(negedge clk);
        chk("restart_irq_pulses", irq_cnt - b, 32'd1);
        chk("restart_irq_edge", irq_edge, e0 + 200);
        ra = sat(raw_edges(e0, 200), 24);
        wb_read(32'h8, r, r8);
        chk("restart_result", r, ra);

        // Start accepted from DONE; old RESULT stays visible until the new run finishes.
        wb_write(32'h4, 32'd40, 4'hF, e);
        b = irq_cnt;
        wb_write(32'h0, 32'h1, 4'h1, e0);
        wb_read(32'h0, r, r8);
        chk("from_done_busy", r, 32'd2);
        wb_read(32'h8, r, r8);
        chk("from_done_result_kept", r, ra);
        repeat (45) @(negedge clk);
        chk("from_done_irq_edge", irq_edge, e0 + 40);
        chk("from_done_irq_pulses", irq_cnt - b, 32'd1);
        wb_read(32'h8, r, r8);
        chk("from_done_result_new", r, sat(raw_edges(e0, 40), 24));
        wb_write(32'h0, 32'h4, 4'h1, e);
        wb_read(32'h0, r, r8);
        chk("w1c_to_idle", r, 32'd0);

        wb_write(32'h4, 32'hFFFF_FFFF, 4'hF, e);
        wb_write(32'h4, 32'h1234_5678, 4'b0101, e);
        wb_read(32'h4, r, r8);
        chk("gate_byte_sel", r, 32'hFF34_FF78);
        chk("gate_byte_sel8", r8, 32'hFF34_FF78);

        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) chk("ack_latency", ack, 1'b1);
            if (ack) n++;
        end
        stb = 1'b0; cyc = 1'b0;
        @(negedge clk);
        chk("ack_single_pulse", n, 32'd1);

        mode = -3;
        repeat (10) @(negedge clk);
        wb_read(32'hC, r, r8);
        chk("level_high", r, 32'd1);
        wb_read(32'h1C, r, r8);
        chk("level_alias", r, 32'd1);
        mode = 0;
        repeat (10) @(negedge clk);
        wb_read(32'hC, r, r8);
        chk("level_low", r, 32'd0);

        mode = -2;
        repeat (8) @(negedge clk);
        wb_write(32'h4, 32'd50, 4'hF, e);
        wb_write(32'h0, 32'h1, 4'h1, e0);
        repeat (56) @(negedge clk);
        raw = raw_edges(e0, 50);
        wb_read(32'h8, r, r8);
        chk("pulse_result_model", r, raw);
`ifdef SKULLFET_FMETER_GLITCH_FILTER_EN
        chk("pulse_result_filtered", r, 32'd0);
`else
        chk("pulse_result_count", r, 32'd10);
`endif
        wb_write(32'h0, 32'hC, 4'h1, e);

        // Reset mid-count: no completion, everything back to its reset value.
        mode = 0;
        wb_write(32'h4, 32'd1000, 4'hF, e);
        b = irq_cnt;
        wb_write(32'h0, 32'h1, 4'h1, e0);
        repeat (300) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_outputs", {29'd0, ack, irq, |rdat}, 32'd0);
        rst = 1'b0;
        repeat (1100) @(negedge clk);
        chk("midrst_no_irq", irq_cnt - b, 32'd0);
        wb_read(32'h0, r, r8);
        chk("midrst_ctrl", r | r8, 32'd0);
        wb_read(32'h8, r, r8);
        chk("midrst_result", r | r8, 32'd0);
        wb_read(32'h4, r, r8);
        chk("midrst_gate", r, 32'd0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule

// File: doc/skullfet_freq_meter.md
SKULLFET_FREQ_METER -- requirements
Module: skullfet_freq_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 24, edge-count width (8..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (2..4).
REQ-003 SHALL have port wb_clk_i  input  1  sole clock, rising edge.
REQ-004 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sig_in  input  1  asynchronous signal from the skullfet_inverter output pad.
REQ-006 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each  Wishbone classic strobe, cycle, and write enable.
REQ-007 SHALL have ports wbs_sel_i  input  4, wbs_adr_i  input  32, wbs_dat_i  input  32  Wishbone byte select, address, and write data.
REQ-008 SHALL have ports wbs_ack_o  output  1 and wbs_dat_o  output  32  Wishbone acknowledge and read data.
REQ-009 SHALL have port irq_o  output  1  one-cycle measurement-done pulse.

Function
REQ-010 SHALL pass sig_in through SYNC_STAGES flops, then detect rising edges (sync high, previous sync low).
REQ-011 SHALL implement FSM IDLE -> COUNT -> DONE -> IDLE.
REQ-012 IDLE->COUNT SHALL occur on a CTRL write with bit0=1; this load clears edge count and loads gate counter from GATE.
REQ-013 In COUNT: gate counter decrements each cycle; each detected edge increments edge count.
REQ-014 An edge in the same cycle as gate counter reaching 1 SHALL be counted.
REQ-015 Edge count SHALL saturate at 2^CNT_W-1 and set the sticky OVF flag.
REQ-016 COUNT->DONE: RESULT latched, DONE flag set, irq_o high for exactly one cycle.
REQ-017 GATE=0 at start SHALL go directly to DONE with RESULT=0.
REQ-018 Start while in COUNT SHALL be ignored.
REQ-019 Start while in DONE SHALL be accepted; RESULT is retained until the next DONE.
REQ-020 DONE->IDLE SHALL occur on a CTRL write with bit2=1 (write-1-to-clear DONE and OVF).
REQ-021 Register map (word offsets):
  0x0 CTRL: bit0 start (W, reads 0); bit1 busy (R); bit2 done (R/W1C); bit3 ovf (R/W1C).
  0x4 GATE: 32-bit R/W.
  0x8 RESULT: R, zero-extended.
  0xC LEVEL: bit0 = synchronized sig_in (R).
REQ-022 wbs_ack_o SHALL assert one cycle after stb&cyc and last one cycle; it SHALL not re-assert until stb drops.
REQ-023 Writes SHALL honour wbs_sel_i per byte; unmapped reads return 0; only wbs_adr_i[3:2] are decoded.
REQ-024 wbs_dat_o SHALL be 0 when not acking.

Reset
REQ-025 While wb_rst_i is high: state IDLE, GATE=0, RESULT=0, all flags 0, synchronizer 0, wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
REQ-026 Reset asserted mid-COUNT SHALL abort without a DONE/irq; operation resumes on the first clock edge after deassertion.

Configuration
REQ-027 Macro SKULLFET_FMETER_GLITCH_FILTER_EN, when defined, SHALL insert a 3-sample majority filter after the synchronizer, adding 2 cycles of latency; pulses shorter than 2 cycles are rejected.
REQ-028 Without SKULLFET_FMETER_GLITCH_FILTER_EN, edge detection SHALL act directly on synchronizer output; no filter logic is present.

Structure
REQ-029 Package skullfet_pkg SHALL hold the FSM state typedef, register offsets, and CTRL bit indices.
REQ-030 Sub-module skullfet_sync SHALL contain the synchronizer, optional filter, and edge detector; outputs: level, rise.

Verification
REQ-031 Reset during COUNT (GATE=1000, after 300 cycles) -> state IDLE, RESULT=0, no irq_o.
REQ-032 GATE=100, sig_in square wave of period 10 cycles -> RESULT=10 (+/-1); irq_o is a single pulse; CTRL reads done=1, busy=0.
REQ-033 CNT_W=8, GATE=1000, sig_in toggling every cycle -> RESULT=255, ovf=1; writing CTRL=0xC clears done and ovf.
REQ-034 GATE=0, start -> done=1 on the next cycle, RESULT=0.
REQ-035 Start written during COUNT -> gate not reloaded; completion timing unchanged.
REQ-036 With SKULLFET_FMETER_GLITCH_FILTER_EN, 1-cycle sig_in pulses during GATE=50 -> RESULT=0; without the macro -> RESULT equals the number of pulses.
